// File: rtl/sha256_kt_sequencer.sv
// rtl/sha256_kt_sequencer.sv - Kt constant ROM address sequencer for one SHA-256 block
//
// Walks ROM index 0..N_CYCLES-1 once per accepted start, issuing one BRAM read
// per non-stalled RUN cycle, and re-times a copy of each issued slot by the
// BRAM read latency so the phase/round strobes coincide with the Kt word.
//
// Ports:
//   CLK, rst_n                clock, asynchronous active-low reset
//   start                     block request, taken when start && ready
//   stall                     suppress the next issue slot (RUN only)
//   ready, busy               idle / block in progress (RUN or DRAIN)
//   Kt_en, Kt_t               Kt BRAM read enable and address
//   Kt_wr_en, Kt_wr_addr      unused BRAM write port, tied low
//   load_phase, round_valid   aligned slot is a load slot / a round slot
//   round_num                 round index of the aligned slot (0 otherwise)
//   final_add, done           aligned slot is the last ROM entry; done pulse
module sha256_kt_sequencer #(
    parameter int N_CYCLES    = 72,
    parameter int FIRST_ROUND = 7,
    parameter int N_ROUNDS    = 64,
    parameter int RD_LATENCY  = 2
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stall,
    output logic       ready,
    output logic       busy,
    output logic       Kt_en,
    output logic [6:0] Kt_t,
    output logic       Kt_wr_en,
    output logic       Kt_wr_addr,
    output logic       load_phase,
    output logic       round_valid,
    output logic [5:0] round_num,
    output logic       final_add,
    output logic       done
);

    localparam int TW = 7;
    // The strobe registers form the last latency stage, so the slot pipe
    // itself is one stage shorter than the read latency.
    localparam int PD = RD_LATENCY - 1;

    localparam logic [TW-1:0] LAST_T = TW'(N_CYCLES - 1);
    localparam logic [TW-1:0] FR_T   = TW'(FIRST_ROUND);
    localparam logic [TW-1:0] END_T  = TW'(FIRST_ROUND + N_ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          kt_en_q, kt_en_d;
    logic [TW-1:0] kt_t_q, kt_t_d;

    logic          pipe_v_q [PD];
    logic [TW-1:0] pipe_t_q [PD];

    logic          tail_v;
    logic [TW-1:0] tail_t;
    logic [TW-1:0] rel_t;

    logic          lp_q, lp_d;
    logic          rv_q, rv_d;
    logic [5:0]    rn_q, rn_d;
    logic          fa_q, fa_d;
    logic          done_q, done_d;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The first slot (t=0) is issued straight out of IDLE so that it appears
    // the cycle after the start is taken; stall has no say there.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        kt_en_d = 1'b0;
        kt_t_d  = kt_t_q;
        case (state_q)
            S_IDLE: begin
                if (start && ready_q) begin
                    state_d = S_RUN;
                    kt_en_d = 1'b1;
                    kt_t_d  = '0;
                    t_d     = TW'(1);
                end
            end
            S_RUN: begin
                if (!stall) begin
                    kt_en_d = 1'b1;
                    kt_t_d  = t_q;
                    if (t_q == LAST_T) begin
                        t_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Leave as the final-add slot is presented, so ready rises
                // on the following cycle.
                if (fa_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // Decode of the slot leaving the pipe; a stalled issue travels as v=0 and
    // therefore yields no strobe, matching the cleared BRAM output.
    always_comb begin
        tail_v = pipe_v_q[PD-1];
        tail_t = pipe_t_q[PD-1];
        rel_t  = tail_t - FR_T;
        lp_d   = tail_v && (tail_t < FR_T);
        rv_d   = tail_v && (tail_t >= FR_T) && (tail_t < END_T);
        rn_d   = rv_d ? rel_t[5:0] : 6'd0;
        fa_d   = tail_v && (tail_t == LAST_T);
        done_d = fa_d;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            t_q     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            kt_en_q <= 1'b0;
            kt_t_q  <= '0;
            for (int i = 0; i < PD; i++) begin
                pipe_v_q[i] <= 1'b0;
                pipe_t_q[i] <= '0;
            end
            lp_q   <= 1'b0;
            rv_q   <= 1'b0;
            rn_q   <= '0;
            fa_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            t_q     <= t_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            kt_en_q <= kt_en_d;
            kt_t_q  <= kt_t_d;
            pipe_v_q[0] <= kt_en_q;
            pipe_t_q[0] <= kt_t_q;
            for (int i = 1; i < PD; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_t_q[i] <= pipe_t_q[i-1];
            end
            lp_q   <= lp_d;
            rv_q   <= rv_d;
            rn_q   <= rn_d;
            fa_q   <= fa_d;
            done_q <= done_d;
        end
    end

    assign ready       = ready_q;
    assign busy        = busy_q;
    assign Kt_en       = kt_en_q;
    assign Kt_t        = kt_t_q;
    assign Kt_wr_en    = 1'b0;
    assign Kt_wr_addr  = 1'b0;
    assign load_phase  = lp_q;
    assign round_valid = rv_q;
    assign round_num   = rn_q;
    assign final_add   = fa_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sha256_kt_sequencer.sv
// tb/tb_sha256_kt_sequencer.sv - self-checking bench for sha256_kt_sequencer
module tb_sha256_kt_sequencer;

    localparam int NC   = 72;
    localparam int FR   = 7;
    localparam int NR   = 64;
    localparam int LAT  = 2;
    localparam int RING = 4096;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stall;
    logic       ready;
    logic       busy;
    logic       Kt_en;
    logic [6:0] Kt_t;
    logic       Kt_wr_en;
    logic       Kt_wr_addr;
    logic       load_phase;
    logic       round_valid;
    logic [5:0] round_num;
    logic       final_add;
    logic       done;

    sha256_kt_sequencer dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .start      (start),
        .stall      (stall),
        .ready      (ready),
        .busy       (busy),
        .Kt_en      (Kt_en),
        .Kt_t       (Kt_t),
        .Kt_wr_en   (Kt_wr_en),
        .Kt_wr_addr (Kt_wr_addr),
        .load_phase (load_phase),
        .round_valid(round_valid),
        .round_num  (round_num),
        .final_add  (final_add),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int e        = 0;

    // Expected aligned ROM index per edge (slot shown after that edge), -1 = none
    int   exp_al [RING];
    logic m_busy, m_rdy, exp_en;
    int   exp_t, m_next, m_end;

    int cnt_acc, cnt_done, cnt_rv, cnt_lp;
    int first_acc, last_acc, last_done, rn3_at;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at edge %0d", tag, got, exp, e);
        end
    endtask

    task automatic clear_tallies();
        cnt_acc   = 0;
        cnt_done  = 0;
        cnt_rv    = 0;
        cnt_lp    = 0;
        first_acc = -1;
        last_acc  = -1;
        last_done = -1000;
        rn3_at    = -1000;
    endtask

    task automatic issue(input int t);
        exp_en = 1'b1;
        exp_t  = t;
        exp_al[(e + LAT) % RING] = t;
        m_next = t + 1;
        if (t == NC - 1) m_end = e + LAT + 1;
    endtask

    task automatic model_edge();
        logic acc;
        e++;
        exp_al[(e + RING - 1) % RING] = -1;
        if (!rst_n) begin
            exp_en = 1'b0;
            m_busy = 1'b0;
            m_rdy  = 1'b0;
            return;
        end
        acc = m_rdy && start;
        if (m_busy && e == m_end) m_busy = 1'b0;
        exp_en = 1'b0;
        if (acc) begin
            m_busy = 1'b1;
            m_end  = -1;
            cnt_acc++;
            if (cnt_acc == 1) first_acc = e;
            last_acc = e;
            issue(0);
        end else if (m_busy && m_next < NC && !stall) begin
            issue(m_next);
        end
        m_rdy = !m_busy;
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_rdy  = 1'b0;
        exp_en = 1'b0;
        for (int k = 0; k <= LAT + 1; k++) exp_al[(e + k) % RING] = -1;
    endtask

    task automatic check_outputs();
        int al;
        al = rst_n ? exp_al[e % RING] : -1;
        check_eq("Kt_en", int'(Kt_en), int'(exp_en));
        if (!rst_n) check_eq("Kt_t_reset", int'(Kt_t), 0);
        else if (exp_en) check_eq("Kt_t", int'(Kt_t), exp_t);
        check_eq("load_phase", int'(load_phase), int'(al >= 0 && al < FR));
        check_eq("round_valid", int'(round_valid), int'(al >= FR && al < FR + NR));
        check_eq("round_num", int'(round_num), (al >= FR && al < FR + NR) ? al - FR : 0);
        check_eq("final_add", int'(final_add), int'(al == NC - 1));
        check_eq("done", int'(done), int'(al == NC - 1));
        check_eq("ready", int'(ready), int'(m_rdy));
        check_eq("busy", int'(busy), int'(m_busy));
        check_eq("Kt_wr_en", int'(Kt_wr_en), 0);
        check_eq("Kt_wr_addr", int'(Kt_wr_addr), 0);
        if (rst_n) begin
            if (round_valid) cnt_rv++;
            if (load_phase) cnt_lp++;
            if (done) begin
                cnt_done++;
                last_done = e;
            end
            if (round_valid && round_num == 6'd3) rn3_at = e;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < RING; i++) exp_al[i] = -1;
        rst_n  = 1'b0;
        start  = 1'b0;
        stall  = 1'b0;
        m_busy = 1'b0;
        m_rdy  = 1'b0;
        exp_en = 1'b0;
        exp_t  = 0;
        m_next = NC;
        m_end  = -1;
        clear_tallies();

        run(3);
        rst_n = 1'b1;
        run(3);

        // Single block, no stalls
        clear_tallies();
        pulse_start();
        run(80);
        check_eq("t1_accepts", cnt_acc, 1);
        check_eq("t1_done_cycle", last_done - first_acc + 1, 74);
        check_eq("t1_done_count", cnt_done, 1);
        check_eq("t1_round_count", cnt_rv, NR);
        check_eq("t1_load_count", cnt_lp, FR);

        // Stall on issue of t=10 and t=11
        clear_tallies();
        pulse_start();
        run(9);
        stall = 1'b1;
        run(2);
        stall = 1'b0;
        run(80);
        check_eq("t2_round3_cycle", rn3_at - first_acc + 1, 15);
        check_eq("t2_done_cycle", last_done - first_acc + 1, 76);
        check_eq("t2_round_count", cnt_rv, NR);
        check_eq("t2_done_count", cnt_done, 1);

        // Stall held in IDLE, at the accept edge and throughout DRAIN
        clear_tallies();
        stall = 1'b1;
        run(3);
        pulse_start();
        stall = 1'b0;
        run(71);
        stall = 1'b1;
        run(10);
        stall = 1'b0;
        check_eq("t3_done_cycle", last_done - first_acc + 1, 74);
        check_eq("t3_done_count", cnt_done, 1);
        check_eq("t3_round_count", cnt_rv, NR);

        // start held high: blocks at 0, 75, 150
        clear_tallies();
        start = 1'b1;
        run(151);
        start = 1'b0;
        run(80);
        check_eq("t4_accepts", cnt_acc, 3);
        check_eq("t4_accept_span", last_acc - first_acc, 150);
        check_eq("t4_done_count", cnt_done, 3);
        check_eq("t4_round_count", cnt_rv, 3 * NR);

        // Reset in cycle 40 of a block
        clear_tallies();
        pulse_start();
        run(39);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        step();
        rst_n = 1'b1;
        run(4);
        check_eq("t5_no_done_after_abort", cnt_done, 0);
        clear_tallies();
        pulse_start();
        run(80);
        check_eq("t5_accepts", cnt_acc, 1);
        check_eq("t5_done_cycle", last_done - first_acc + 1, 74);
        check_eq("t5_round_count", cnt_rv, NR);
        check_eq("t5_load_count", cnt_lp, FR);

        // Random stalls, ~10% density
        for (int b = 0; b < 4; b++) begin
            clear_tallies();
            for (int w = 0; w < 10 && !m_rdy; w++) step();
            pulse_start();
            for (int c = 0; c < 200 && cnt_done == 0; c++) begin
                stall = ($urandom_range(9, 0) == 0);
                step();
            end
            stall = 1'b0;
            run(2);
            check_eq("t6_accepts", cnt_acc, 1);
            check_eq("t6_done_count", cnt_done, 1);
            check_eq("t6_round_count", cnt_rv, NR);
            check_eq("t6_load_count", cnt_lp, FR);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
